// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: sequencing controller between the PS/2 receive FIFO and the
// seven-segment display logic.
//
// It pops one byte at a time from the FIFO using a WAIT -> POP -> GAP cycle.
// It strips E0 (extended) and F0 (break) prefixes and tracks the held key.
// Typematic repeats of the held key are suppressed, and distinct presses are
// counted.
//
// Ports:
//   clk             system clock
//   rstn            synchronous reset, active-high (historical name)
//   fifo_data       head byte of the PS/2 FIFO
//   fifo_ready      FIFO non-empty, fifo_data valid
//   fifo_overflow   FIFO overflow flag
//   fifo_nextdata_n pop strobe, active-low, one cycle per byte
//   key_code        scan code of the last pressed key (prefix stripped)
//   key_ext         last pressed key carried an E0 prefix
//   key_held        last pressed key is still down
//   disp_en         segment enable, mirrors key_held
//   key_count       distinct presses, modulo 2^CNT_WIDTH
//   event_valid     one-cycle pulse per make/break event
//   event_break     qualifies event_valid: 1 = release, 0 = press
//   overflow_sticky set once fifo_overflow seen, cleared only by reset
module ps2_key_ctrl #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [7:0]           fifo_data,
  input  logic                 fifo_ready,
  input  logic                 fifo_overflow,
  output logic                 fifo_nextdata_n,
  output logic [7:0]           key_code,
  output logic                 key_ext,
  output logic                 key_held,
  output logic                 disp_en,
  output logic [CNT_WIDTH-1:0] key_count,
  output logic                 event_valid,
  output logic                 event_break,
  output logic                 overflow_sticky
);

  localparam logic [7:0] ExtPrefix = 8'hE0;
  localparam logic [7:0] BrkPrefix = 8'hF0;

  typedef enum logic [1:0] {StWait, StPop, StGap} state_e;

  state_e               state_q, state_d;
  logic [7:0]           byte_q, byte_d;
  logic                 nextdata_n_q, nextdata_n_d;
  logic [7:0]           key_code_q, key_code_d;
  logic                 key_ext_q, key_ext_d;
  logic                 key_held_q, key_held_d;
  logic [CNT_WIDTH-1:0] key_count_q, key_count_d;
  logic                 event_valid_q, event_valid_d;
  logic                 event_break_q, event_break_d;
  logic                 ovf_q, ovf_d;
  logic                 ext_pend_q, ext_pend_d;
  logic                 brk_pend_q, brk_pend_d;

  logic key_match;
  logic is_repeat;

  // A byte (with its pending E0 flag) naming the current key; a repeat only
  // counts while that key is actually down.
  assign key_match = (byte_q == key_code_q) && (ext_pend_q == key_ext_q);
  assign is_repeat = key_held_q && key_match;

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    nextdata_n_d  = nextdata_n_q;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_held_d    = key_held_q;
    key_count_d   = key_count_q;
    event_valid_d = event_valid_q;
    event_break_d = event_break_q;
    ovf_d         = ovf_q | fifo_overflow;
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;

    case (state_q)
      StWait: begin
        if (fifo_ready) begin
          byte_d       = fifo_data;
          nextdata_n_d = 1'b0;
          state_d      = StPop;
        end
      end

      StPop: begin
        nextdata_n_d = 1'b1;
        state_d      = StGap;
        if (byte_q == ExtPrefix) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == BrkPrefix) begin
          brk_pend_d = 1'b1;
        end else begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          if (!brk_pend_q) begin
            if (!is_repeat) begin
              key_code_d    = byte_q;
              key_ext_d     = ext_pend_q;
              key_held_d    = 1'b1;
              key_count_d   = key_count_q + CNT_WIDTH'(1);
              event_valid_d = 1'b1;
              event_break_d = 1'b0;
            end
          end else begin
            // Releases always report an event; only a matching one drops the key.
            event_valid_d = 1'b1;
            event_break_d = 1'b1;
            if (key_match) begin
              key_held_d = 1'b0;
            end
          end
        end
      end

      StGap: begin
        // Gives fifo_ready a cycle to settle after the pop.
        event_valid_d = 1'b0;
        state_d       = StWait;
      end

      default: begin
        state_d = StWait;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q       <= StWait;
      byte_q        <= 8'h00;
      nextdata_n_q  <= 1'b1;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_held_q    <= 1'b0;
      key_count_q   <= '0;
      event_valid_q <= 1'b0;
      event_break_q <= 1'b0;
      ovf_q         <= 1'b0;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      nextdata_n_q  <= nextdata_n_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_held_q    <= key_held_d;
      key_count_q   <= key_count_d;
      event_valid_q <= event_valid_d;
      event_break_q <= event_break_d;
      ovf_q         <= ovf_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
    end
  end

  assign fifo_nextdata_n = nextdata_n_q;
  assign key_code        = key_code_q;
  assign key_ext         = key_ext_q;
  assign key_held        = key_held_q;
  assign disp_en         = key_held_q;
  assign key_count       = key_count_q;
  assign event_valid     = event_valid_q;
  assign event_break     = event_break_q;
  assign overflow_sticky = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Testbench for ps2_key_ctrl: table of single-byte vectors with expected
// outputs, plus hand-written sequences for reset, counter wrap with pop
// spacing, overflow and reset in the POP cycle.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] fifo_data;
  logic       fifo_ready;
  logic       fifo_overflow;
  logic       fifo_nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_held;
  logic       disp_en;
  logic [7:0] key_count;
  logic       event_valid;
  logic       event_break;
  logic       overflow_sticky;

  ps2_key_ctrl #(.CNT_WIDTH(8)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .fifo_data       (fifo_data),
    .fifo_ready      (fifo_ready),
    .fifo_overflow   (fifo_overflow),
    .fifo_nextdata_n (fifo_nextdata_n),
    .key_code        (key_code),
    .key_ext         (key_ext),
    .key_held        (key_held),
    .disp_en         (disp_en),
    .key_count       (key_count),
    .event_valid     (event_valid),
    .event_break     (event_break),
    .overflow_sticky (overflow_sticky)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic prev_low = 1'b0;
  logic dbl_low = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pop strobe must never be low on two consecutive cycles.
  always @(negedge clk) begin
    if (!fifo_nextdata_n) begin
      if (prev_low) dbl_low <= 1'b1;
      prev_low <= 1'b1;
    end else begin
      prev_low <= 1'b0;
    end
  end

  int n_checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic       ev;
    logic       brk;
    logic [7:0] code;
    logic       ext;
    logic       held;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [7:0] b, input logic ev, input logic brk,
                     input logic [7:0] code, input logic ext, input logic held,
                     input logic [7:0] cnt);
    vec_t v;
    v.b = b; v.ev = ev; v.brk = brk; v.code = code; v.ext = ext; v.held = held; v.cnt = cnt;
    vt.push_back(v);
  endtask

  // Present one byte, wait for its pop, then stop at the negedge after the
  // decode edge with fifo_ready dropped (the next call may raise it again at
  // the same instant, so back-to-back calls keep the FIFO continuously ready).
  task automatic send_byte(input logic [7:0] b, output int pop_cyc);
    logic seen;
    fifo_data  = b;
    fifo_ready = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (!fifo_nextdata_n) seen = 1'b1;
    end
    chk("pop_seen", {31'd0, seen}, 32'd1);
    pop_cyc = cyc;
    @(negedge clk);
    fifo_ready = 1'b0;
    chk("pop_one_cycle", {31'd0, fifo_nextdata_n}, 32'd1);
  endtask

  task automatic chk_outputs(input string tag, input vec_t v);
    chk({tag, "_event_valid"}, {31'd0, event_valid}, {31'd0, v.ev});
    if (v.ev) chk({tag, "_event_break"}, {31'd0, event_break}, {31'd0, v.brk});
    chk({tag, "_key_code"}, {24'd0, key_code}, {24'd0, v.code});
    chk({tag, "_key_ext"}, {31'd0, key_ext}, {31'd0, v.ext});
    chk({tag, "_key_held"}, {31'd0, key_held}, {31'd0, v.held});
    chk({tag, "_disp_en"}, {31'd0, disp_en}, {31'd0, v.held});
    chk({tag, "_key_count"}, {24'd0, key_count}, {24'd0, v.cnt});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_nextdata_n"}, {31'd0, fifo_nextdata_n}, 32'd1);
    chk({tag, "_key_code"}, {24'd0, key_code}, 32'd0);
    chk({tag, "_key_ext"}, {31'd0, key_ext}, 32'd0);
    chk({tag, "_key_held"}, {31'd0, key_held}, 32'd0);
    chk({tag, "_disp_en"}, {31'd0, disp_en}, 32'd0);
    chk({tag, "_key_count"}, {24'd0, key_count}, 32'd0);
    chk({tag, "_event_valid"}, {31'd0, event_valid}, 32'd0);
    chk({tag, "_event_break"}, {31'd0, event_break}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow_sticky}, 32'd0);
  endtask

  initial begin
    int   pc;
    int   prev_pc;
    int   bad_spacing;
    logic seen;
    vec_t v;

    // b     ev brk code  ext held cnt
    add(8'h1C, 1, 0, 8'h1C, 0, 1, 8'd1); // single press
    add(8'h1C, 0, 0, 8'h1C, 0, 1, 8'd1); // typematic repeats
    add(8'h1C, 0, 0, 8'h1C, 0, 1, 8'd1);
    add(8'h1C, 0, 0, 8'h1C, 0, 1, 8'd1);
    add(8'hF0, 0, 0, 8'h1C, 0, 1, 8'd1);
    add(8'h1C, 1, 1, 8'h1C, 0, 0, 8'd1); // release
    add(8'hE0, 0, 0, 8'h1C, 0, 0, 8'd1);
    add(8'h75, 1, 0, 8'h75, 1, 1, 8'd2); // extended make
    add(8'hE0, 0, 0, 8'h75, 1, 1, 8'd2);
    add(8'h75, 0, 0, 8'h75, 1, 1, 8'd2); // extended repeat
    add(8'hF0, 0, 0, 8'h75, 1, 1, 8'd2);
    add(8'h74, 1, 1, 8'h75, 1, 1, 8'd2); // non-matching release
    add(8'hE0, 0, 0, 8'h75, 1, 1, 8'd2);
    add(8'hF0, 0, 0, 8'h75, 1, 1, 8'd2);
    add(8'h75, 1, 1, 8'h75, 1, 0, 8'd2); // extended release
    add(8'h75, 1, 0, 8'h75, 0, 1, 8'd3); // plain make of same code
    add(8'hE0, 0, 0, 8'h75, 0, 1, 8'd3);
    add(8'hF0, 0, 0, 8'h75, 0, 1, 8'd3);
    add(8'h75, 1, 1, 8'h75, 0, 1, 8'd3); // ext mismatch: key stays held
    add(8'hF0, 0, 0, 8'h75, 0, 1, 8'd3);
    add(8'hF0, 0, 0, 8'h75, 0, 1, 8'd3);
    add(8'h75, 1, 1, 8'h75, 0, 0, 8'd3); // doubled F0 is idempotent
    add(8'hE0, 0, 0, 8'h75, 0, 0, 8'd3);
    add(8'hE0, 0, 0, 8'h75, 0, 0, 8'd3);
    add(8'h75, 1, 0, 8'h75, 1, 1, 8'd4); // doubled E0 is idempotent
    add(8'hF0, 0, 0, 8'h75, 1, 1, 8'd4);
    add(8'hE0, 0, 0, 8'h75, 1, 1, 8'd4);
    add(8'h75, 1, 1, 8'h75, 1, 0, 8'd4); // F0 E0 order sets both flags
    add(8'h75, 1, 0, 8'h75, 0, 1, 8'd5); // same code, not held: new press

    // Reset held two cycles with the FIFO ready: no pop, all outputs zero.
    rstn          = 1'b1;
    fifo_ready    = 1'b1;
    fifo_data     = 8'h1C;
    fifo_overflow = 1'b0;
    @(negedge clk);
    chk("rst_c1_nextdata_n", {31'd0, fifo_nextdata_n}, 32'd1);
    @(negedge clk);
    chk_reset_state("rst");
    fifo_ready = 1'b0;
    rstn       = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      send_byte(v.b, pc);
      chk_outputs($sformatf("vec%0d", i), v);
    end
    @(negedge clk);
    chk("vec_pulse_end", {31'd0, event_valid}, 32'd0);

    // Counter wrap with the FIFO continuously ready; pops 3 cycles apart.
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    prev_pc     = -1;
    bad_spacing = 0;
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h16, pc);
      if (prev_pc >= 0 && pc - prev_pc != 3) bad_spacing++;
      prev_pc = pc;
      if (i == 254) chk("wrap_cnt_255", {24'd0, key_count}, 32'hFF);
      if (i == 255) chk("wrap_cnt_256", {24'd0, key_count}, 32'h00);
      send_byte(8'hF0, pc);
      if (pc - prev_pc != 3) bad_spacing++;
      prev_pc = pc;
      send_byte(8'h16, pc);
      if (pc - prev_pc != 3) bad_spacing++;
      prev_pc = pc;
    end
    chk("pop_spacing_bad", bad_spacing, 32'd0);
    chk("wrap_held", {31'd0, key_held}, 32'd0);
    chk("wrap_code", {24'd0, key_code}, 32'h16);

    // Overflow stickiness, then reset landing in the POP cycle.
    @(negedge clk);
    fifo_overflow = 1'b1;
    @(negedge clk);
    fifo_overflow = 1'b0;
    chk("ovf_set", {31'd0, overflow_sticky}, 32'd1);
    send_byte(8'hE0, pc);
    chk("ovf_held", {31'd0, overflow_sticky}, 32'd1);
    fifo_data  = 8'h75;
    fifo_ready = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (!fifo_nextdata_n) seen = 1'b1;
    end
    chk("midrst_pop_seen", {31'd0, seen}, 32'd1);
    rstn = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    rstn = 1'b0;
    send_byte(8'h75, pc);
    v.b = 8'h75; v.ev = 1'b1; v.brk = 1'b0; v.code = 8'h75; v.ext = 1'b0;
    v.held = 1'b1; v.cnt = 8'd1;
    chk_outputs("after_rst", v);
    @(negedge clk);
    chk("after_rst_pulse_end", {31'd0, event_valid}, 32'd0);

    chk("no_double_pop_low", {31'd0, dbl_low}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
